// File: rtl/matrix_access_arbiter.sv
// Round-robin arbiter sharing the single-ported matrix between NUM_REQ requesters, one
// transaction in flight. Define MATRIX_ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
module matrix_access_arbiter #(
  parameter int unsigned NUM_ROWS       = 4,
  parameter int unsigned NUM_COLS       = 5,
  parameter int unsigned SCALAR_BITS    = 32,
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned ROW_ADDR_WIDTH = $clog2(NUM_ROWS),
  localparam int unsigned COL_ADDR_WIDTH = $clog2(NUM_COLS),
  localparam int unsigned DATA_W =
      ((NUM_COLS > NUM_ROWS) ? NUM_COLS : NUM_ROWS) * SCALAR_BITS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 cmd_valid,
  input  logic [2*NUM_REQ-1:0]               cmd_op,
  input  logic [ROW_ADDR_WIDTH*NUM_REQ-1:0]  cmd_row_addr,
  input  logic [COL_ADDR_WIDTH*NUM_REQ-1:0]  cmd_col_addr,
  input  logic [SCALAR_BITS*NUM_REQ-1:0]     cmd_data,
  output logic [NUM_REQ-1:0]                 cmd_accept,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DATA_W-1:0]                  rsp_data,
  output logic                               rsp_err,
  output logic [ROW_ADDR_WIDTH-1:0]          row_addr,
  output logic                               row_addr_ready,
  input  logic                               row_valid,
  input  logic [NUM_COLS*SCALAR_BITS-1:0]    row_out,
  output logic [COL_ADDR_WIDTH-1:0]          col_addr,
  output logic                               col_addr_ready,
  input  logic                               col_valid,
  input  logic [NUM_ROWS*SCALAR_BITS-1:0]    col_out,
  output logic [ROW_ADDR_WIDTH-1:0]          write_row_addr,
  output logic [COL_ADDR_WIDTH-1:0]          write_col_addr,
  output logic [SCALAR_BITS-1:0]             write_data,
  output logic                               write_ready
);

  localparam int unsigned GrantW = $clog2(NUM_REQ);

  localparam logic [1:0] OpRdRow = 2'b00;
  localparam logic [1:0] OpRdCol = 2'b01;
  localparam logic [1:0] OpWrite = 2'b10;
  localparam logic [1:0] OpRsvd  = 2'b11;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                     state_q, state_d;
  logic [GrantW-1:0]          last_grant_q, last_grant_d;
  logic [GrantW-1:0]          grant_q, grant_d;
  logic [1:0]                 op_q, op_d;
  logic                       err_q, err_d;
  logic [DATA_W-1:0]          rsp_data_q, rsp_data_d;
  logic [ROW_ADDR_WIDTH-1:0]  row_addr_q, row_addr_d;
  logic [COL_ADDR_WIDTH-1:0]  col_addr_q, col_addr_d;
  logic [ROW_ADDR_WIDTH-1:0]  wr_row_q, wr_row_d;
  logic [COL_ADDR_WIDTH-1:0]  wr_col_q, wr_col_d;
  logic [SCALAR_BITS-1:0]     wr_data_q, wr_data_d;

`ifdef MATRIX_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0]            cnt_q, cnt_d;
`endif

  // Round-robin pick: first valid requester at or after last_grant+1.
  logic              found;
  logic [GrantW-1:0] pick;
  int                cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand = (int'(last_grant_q) + 1 + i) % int'(NUM_REQ);
      if (!found && cmd_valid[cand]) begin
        found = 1'b1;
        pick  = GrantW'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    op_d         = op_q;
    err_d        = err_q;
    rsp_data_d   = rsp_data_q;
    row_addr_d   = row_addr_q;
    col_addr_d   = col_addr_q;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    wr_data_d    = wr_data_q;
    cmd_accept   = '0;
`ifdef MATRIX_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (found) begin
          cmd_accept[pick] = 1'b1;
          grant_d          = pick;
          last_grant_d     = pick;
          op_d             = cmd_op[2*pick +: 2];
          // Only the port this op uses picks up new addresses; the others hold.
          unique case (cmd_op[2*pick +: 2])
            OpRdRow: row_addr_d = cmd_row_addr[ROW_ADDR_WIDTH*pick +: ROW_ADDR_WIDTH];
            OpRdCol: col_addr_d = cmd_col_addr[COL_ADDR_WIDTH*pick +: COL_ADDR_WIDTH];
            OpWrite: begin
              wr_row_d  = cmd_row_addr[ROW_ADDR_WIDTH*pick +: ROW_ADDR_WIDTH];
              wr_col_d  = cmd_col_addr[COL_ADDR_WIDTH*pick +: COL_ADDR_WIDTH];
              wr_data_d = cmd_data[SCALAR_BITS*pick +: SCALAR_BITS];
            end
            default: ;
          endcase
          state_d = StIssue;
        end
      end

      StIssue: begin
        err_d = (op_q == OpRsvd);
`ifdef MATRIX_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (op_q == OpRdRow || op_q == OpRdCol) begin
          state_d = StWait;
        end else begin
          state_d = StResp;
        end
      end

      StWait: begin
        if (op_q == OpRdRow && row_valid) begin
          rsp_data_d = DATA_W'(row_out);
          state_d    = StResp;
        end else if (op_q == OpRdCol && col_valid) begin
          rsp_data_d = DATA_W'(col_out);
          state_d    = StResp;
        end
`ifdef MATRIX_ARB_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d = '0;
          err_d      = 1'b1;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      StResp: begin
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= GrantW'(NUM_REQ - 1);
      grant_q      <= '0;
      op_q         <= '0;
      err_q        <= 1'b0;
      rsp_data_q   <= '0;
      row_addr_q   <= '0;
      col_addr_q   <= '0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      wr_data_q    <= '0;
`ifdef MATRIX_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      op_q         <= op_d;
      err_q        <= err_d;
      rsp_data_q   <= rsp_data_d;
      row_addr_q   <= row_addr_d;
      col_addr_q   <= col_addr_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      wr_data_q    <= wr_data_d;
`ifdef MATRIX_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == StResp) begin
      rsp_valid[grant_q] = 1'b1;
    end
  end

  assign rsp_err        = (state_q == StResp) && err_q;
  assign rsp_data       = rsp_data_q;
  assign row_addr       = row_addr_q;
  assign col_addr       = col_addr_q;
  assign write_row_addr = wr_row_q;
  assign write_col_addr = wr_col_q;
  assign write_data     = wr_data_q;
  assign row_addr_ready = (state_q == StIssue) && (op_q == OpRdRow);
  assign col_addr_ready = (state_q == StIssue) && (op_q == OpRdCol);
  assign write_ready    = (state_q == StIssue) && (op_q == OpWrite);

endmodule
